// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the LUMOS multi-cycle sequencer (master) and the datapath/memory side (slave).
// Optional macro PERF_CNT_EN adds the instret/cycles performance counter signals.
interface multicycle_ctrl_fsm_if;
    logic [2:0]  opcode;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        PCSource;
    logic        IRWrite;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUop;
    logic        ExtOp;
    logic        Branch;
    logic        instr_done;
    logic        bus_err;
    logic [3:0]  state;
`ifdef PERF_CNT_EN
    logic [31:0] instret;
    logic [31:0] cycles;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IRWrite, IorD, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, ExtOp, Branch,
               instr_done, bus_err, state, instret, cycles
    );
    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IRWrite, IorD, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, ExtOp, Branch,
               instr_done, bus_err, state, instret, cycles
    );
`else
    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IRWrite, IorD, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, ExtOp, Branch,
               instr_done, bus_err, state
    );
    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IRWrite, IorD, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, ExtOp, Branch,
               instr_done, bus_err, state
    );
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 3-bit-opcode LUMOS datapath with bounded memory waits.
// Optional macro PERF_CNT_EN adds retired-instruction and cycle counters.
module multicycle_ctrl_fsm #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        WB_R     = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       branch;
        logic       instr_done;
        logic       bus_err;
    } ctrl_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_ORI  = 3'b111;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_t            ctrl;
    logic             timeout;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl       = '0;
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = '0;
        timeout    = (wait_cnt_q == WAIT_LAST) && !bus.mem_ready;

        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.ir_write = 1'b1;
                    state_d       = DECODE;
                end else if (timeout) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.ext_op    = 1'b1;
                op_d           = bus.opcode;
                case (bus.opcode)
                    OP_ADD, OP_SUB, OP_AND: state_d = EXEC_R;
                    OP_ADDI, OP_ORI:        state_d = EXEC_I;
                    OP_LW, OP_SW:           state_d = MEM_ADDR;
                    OP_BEQ:                 state_d = BRANCH;
                    default:                state_d = FETCH;
                endcase
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                case (op_q)
                    OP_SUB:  ctrl.alu_op = 2'b01;
                    OP_AND:  ctrl.alu_op = 2'b10;
                    default: ctrl.alu_op = 2'b00;
                endcase
                state_d = WB_R;
            end
            WB_R: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                if (op_q == OP_ORI) begin
                    ctrl.alu_op = 2'b11;
                    ctrl.ext_op = 1'b0;
                end else begin
                    ctrl.alu_op = 2'b00;
                    ctrl.ext_op = 1'b1;
                end
                state_d = WB_I;
            end
            WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.ext_op    = 1'b1;
                state_d        = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEM_WB;
                end else if (timeout) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = FETCH;
                end else if (timeout) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                ctrl.branch        = 1'b1;
                ctrl.instr_done    = 1'b1;
                state_d            = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Strobes are forced quiet for the whole reset cycle, whatever the state register holds.
        if (!rst_n) ctrl = '0;
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemToReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUop       = ctrl.alu_op;
    assign bus.ExtOp       = ctrl.ext_op;
    assign bus.Branch      = ctrl.branch;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.bus_err     = ctrl.bus_err;
    assign bus.state       = rst_n ? state_q : 4'd0;

`ifdef PERF_CNT_EN
    logic [31:0] instret_q, cycles_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (ctrl.instr_done) instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.instret = rst_n ? instret_q : 32'd0;
    assign bus.cycles  = rst_n ? cycles_q  : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm: per-cycle expected control words queued, then popped and compared.
module tb_multicycle_ctrl_fsm;

    localparam int WAIT_LIMIT = 15;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, pcsrc, irw, iord, mrd, mwr, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop;
        logic       ext, br, done, err;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state;       o.pcw = bus.PCWrite;    o.pcwc = bus.PCWriteCond;
        o.pcsrc = bus.PCSource; o.irw = bus.IRWrite;    o.iord = bus.IorD;
        o.mrd = bus.MemRead;    o.mwr = bus.MemWrite;   o.m2r = bus.MemToReg;
        o.rdst = bus.RegDst;    o.rw = bus.RegWrite;    o.srca = bus.ALUSrcA;
        o.srcb = bus.ALUSrcB;   o.aluop = bus.ALUop;    o.ext = bus.ExtOp;
        o.br = bus.Branch;      o.done = bus.instr_done; o.err = bus.bus_err;
        return o;
    endfunction

    // Expected control words, one constructor per architectural state.
    function automatic obs_t e_zero();
        obs_t e = '0;
        return e;
    endfunction
    function automatic obs_t e_fetch(input logic mr, input logic err);
        obs_t e = '0;
        e.st = 4'd0; e.mrd = 1'b1; e.srcb = 2'b01; e.pcw = mr; e.irw = mr; e.err = err;
        return e;
    endfunction
    function automatic obs_t e_decode();
        obs_t e = '0;
        e.st = 4'd1; e.srcb = 2'b11; e.ext = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_exec_r(input logic [1:0] aluop);
        obs_t e = '0;
        e.st = 4'd2; e.srca = 1'b1; e.aluop = aluop;
        return e;
    endfunction
    function automatic obs_t e_wb_r();
        obs_t e = '0;
        e.st = 4'd8; e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_exec_i(input logic [1:0] aluop, input logic ext);
        obs_t e = '0;
        e.st = 4'd3; e.srca = 1'b1; e.srcb = 2'b10; e.aluop = aluop; e.ext = ext;
        return e;
    endfunction
    function automatic obs_t e_wb_i();
        obs_t e = '0;
        e.st = 4'd9; e.rw = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_mem_addr();
        obs_t e = '0;
        e.st = 4'd4; e.srca = 1'b1; e.srcb = 2'b10; e.ext = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_mem_rd(input logic err);
        obs_t e = '0;
        e.st = 4'd5; e.iord = 1'b1; e.mrd = 1'b1; e.err = err;
        return e;
    endfunction
    function automatic obs_t e_mem_wb();
        obs_t e = '0;
        e.st = 4'd6; e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_mem_wr(input logic done, input logic err);
        obs_t e = '0;
        e.st = 4'd7; e.iord = 1'b1; e.mwr = 1'b1; e.done = done; e.err = err;
        return e;
    endfunction
    function automatic obs_t e_branch();
        obs_t e = '0;
        e.st = 4'd10; e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1;
        e.pcsrc = 1'b1; e.br = 1'b1; e.done = 1'b1;
        return e;
    endfunction

    // One clock: drive inputs, queue the expectation, compare mid-cycle, advance past the edge.
    task automatic step(input logic r, input logic [2:0] op, input logic mr,
                        input obs_t e, input string tag);
        exp_t x;
        exp_t y;
        obs_t got;
        rst_n         = r;
        bus.opcode    = op;
        bus.mem_ready = mr;
        x.v   = e;
        x.tag = tag;
        sb.push_back(x);
        @(negedge clk);
        got = sample();
        y   = sb.pop_front();
        checks++;
        assert (got === y.v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", y.tag, got, y.v);
        end
        @(posedge clk);
        #1;
    endtask

    // Zero-wait four-cycle register-register instruction; other cycles drive a decoy opcode.
    task automatic r_type(input logic [2:0] op, input logic [1:0] aluop, input string tag);
        step(1'b1, ~op, 1'b1, e_fetch(1'b1, 1'b0), {tag, "_fetch"});
        step(1'b1, op,  1'b1, e_decode(),          {tag, "_decode"});
        step(1'b1, ~op, 1'b1, e_exec_r(aluop),     {tag, "_exec"});
        step(1'b1, ~op, 1'b1, e_wb_r(),            {tag, "_wb"});
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 3'b000;
        bus.mem_ready = 1'b1;

        step(1'b0, 3'b000, 1'b1, e_zero(), "reset0");
        step(1'b0, 3'b000, 1'b1, e_zero(), "reset1");

        r_type(3'b000, 2'b00, "add");
        r_type(3'b001, 2'b01, "sub");
        r_type(3'b011, 2'b10, "and");

        // lw with three wait states in MEM_RD: 8 cycles total
        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0), "lw_fetch");
        step(1'b1, 3'b100, 1'b1, e_decode(),          "lw_decode");
        step(1'b1, 3'b101, 1'b1, e_mem_addr(),        "lw_addr");
        for (int i = 0; i < 3; i++) step(1'b1, 3'b101, 1'b0, e_mem_rd(1'b0), "lw_rd_wait");
        step(1'b1, 3'b101, 1'b1, e_mem_rd(1'b0),      "lw_rd_done");
        step(1'b1, 3'b101, 1'b1, e_mem_wb(),          "lw_wb");

        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0),   "ori_fetch");
        step(1'b1, 3'b111, 1'b1, e_decode(),            "ori_decode");
        step(1'b1, 3'b110, 1'b1, e_exec_i(2'b11, 1'b0), "ori_exec");
        step(1'b1, 3'b110, 1'b1, e_wb_i(),              "ori_wb");

        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0),   "addi_fetch");
        step(1'b1, 3'b110, 1'b1, e_decode(),            "addi_decode");
        step(1'b1, 3'b111, 1'b1, e_exec_i(2'b00, 1'b1), "addi_exec");
        step(1'b1, 3'b111, 1'b1, e_wb_i(),              "addi_wb");

        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0), "beq_fetch");
        step(1'b1, 3'b010, 1'b1, e_decode(),          "beq_decode");
        step(1'b1, 3'b000, 1'b1, e_branch(),          "beq_branch");

        // sw zero-wait: 4 cycles
        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0),  "sw_fetch");
        step(1'b1, 3'b101, 1'b1, e_decode(),           "sw_decode");
        step(1'b1, 3'b100, 1'b1, e_mem_addr(),         "sw_addr");
        step(1'b1, 3'b100, 1'b1, e_mem_wr(1'b1, 1'b0), "sw_wr");

        // sw timeout: bus_err on the WAIT_LIMIT-th stalled cycle, no instr_done
        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0), "swto_fetch");
        step(1'b1, 3'b101, 1'b1, e_decode(),          "swto_decode");
        step(1'b1, 3'b000, 1'b1, e_mem_addr(),        "swto_addr");
        for (int i = 0; i < WAIT_LIMIT - 1; i++)
            step(1'b1, 3'b000, 1'b0, e_mem_wr(1'b0, 1'b0), "swto_wait");
        step(1'b1, 3'b000, 1'b0, e_mem_wr(1'b0, 1'b1), "swto_abort");
        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0),  "swto_refetch");

        // same stall, but the memory answers on the last allowed cycle
        step(1'b1, 3'b101, 1'b1, e_decode(),          "swlate_decode");
        step(1'b1, 3'b000, 1'b1, e_mem_addr(),        "swlate_addr");
        for (int i = 0; i < WAIT_LIMIT - 1; i++)
            step(1'b1, 3'b000, 1'b0, e_mem_wr(1'b0, 1'b0), "swlate_wait");
        step(1'b1, 3'b000, 1'b1, e_mem_wr(1'b1, 1'b0), "swlate_done");

        // reset in the middle of a MEM_RD wait, then a full-length FETCH stall proves the counter restarted
        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0), "rstmid_fetch");
        step(1'b1, 3'b100, 1'b1, e_decode(),          "rstmid_decode");
        step(1'b1, 3'b000, 1'b1, e_mem_addr(),        "rstmid_addr");
        for (int i = 0; i < 5; i++) step(1'b1, 3'b000, 1'b0, e_mem_rd(1'b0), "rstmid_wait");
        step(1'b0, 3'b000, 1'b0, e_zero(), "rstmid_reset");
        for (int i = 0; i < WAIT_LIMIT - 1; i++)
            step(1'b1, 3'b000, 1'b0, e_fetch(1'b0, 1'b0), "fetch_wait");
        step(1'b1, 3'b000, 1'b0, e_fetch(1'b0, 1'b1), "fetch_abort");
        step(1'b1, 3'b000, 1'b1, e_fetch(1'b1, 1'b0), "fetch_retry");
        step(1'b1, 3'b001, 1'b1, e_decode(),          "fetch_retry_decode");

`ifdef PERF_CNT_EN
        step(1'b0, 3'b000, 1'b1, e_zero(), "perf_reset");
        for (int i = 0; i < 8; i++) r_type(3'b000, 2'b00, "perf_add");
        checks++;
        assert (bus.instret === 32'd8) else begin
            errors++;
            $error("FAIL instret: observed=%0d expected=8", bus.instret);
        end
        checks++;
        assert (bus.cycles === 32'd32) else begin
            errors++;
            $error("FAIL cycles: observed=%0d expected=32", bus.cycles);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
